// File: rtl/mmio_pwm_bank.sv
// Memory-mapped bank of PWM channels sharing one prescaler and period counter.
// Duty values are double-buffered and load into the active set on counter wrap.
module mmio_pwm_bank #(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_mem,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              hit,
    output logic [NUM_CH-1:0] pwm
);

    logic                 sel;
    logic [5:0]           word;
    logic                 wr;
    logic                 en;
    logic [7:0]           presc;
    logic [CNT_WIDTH-1:0] top;
    logic                 wrap_flag;
    logic [7:0]           pcnt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] shadow [NUM_CH];
    logic [CNT_WIDTH-1:0] active [NUM_CH];
    logic [NUM_CH-1:0]    inv;
    logic                 tick;
    logic                 wrap;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign sel  = (address[31:8] == BASE_ADDR[31:8]);
    assign word = address[7:2];
    assign wr   = write_mem && sel;
    assign tick = en && (pcnt == presc);
    // >= lets a lowered TOP take effect on the very next tick
    assign wrap = tick && (cnt >= top);

    assign unused_bits = ^{address[1:0], write_data, BASE_ADDR[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            en        <= 1'b0;
            presc     <= '0;
            top       <= '0;
            wrap_flag <= 1'b0;
        end else begin
            if (wr && word == 6'd0) begin
                en    <= write_data[0];
                presc <= write_data[15:8];
            end
            if (wr && word == 6'd1)
                top <= write_data[CNT_WIDTH-1:0];
            if (wrap)
                wrap_flag <= 1'b1;
            else if (wr && word == 6'd2 && write_data[0])
                wrap_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            pcnt <= '0;
            cnt  <= '0;
        end else if (tick) begin
            pcnt <= '0;
            cnt  <= wrap ? '0 : cnt + CNT_WIDTH'(1);
        end else begin
            pcnt <= pcnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            inv <= '0;
            pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr && word == 6'(i + 4)) begin
                    shadow[i] <= write_data[CNT_WIDTH-1:0];
                    inv[i]    <= write_data[31];
                end
                // nonblocking: a shadow write in the wrap cycle waits a period
                if (!en || wrap)
                    active[i] <= shadow[i];
                pwm[i] <= en && ((cnt < active[i]) ^ inv[i]);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (word)
                6'd0: begin
                    rdata[0]    = en;
                    rdata[15:8] = presc;
                end
                6'd1: rdata[CNT_WIDTH-1:0] = top;
                6'd2: begin
                    rdata[0]             = wrap_flag;
                    rdata[8+:CNT_WIDTH] = cnt;
                end
                default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (word == 6'(i + 4)) begin
                    rdata[CNT_WIDTH-1:0] = shadow[i];
                    rdata[31]            = inv[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
            hit       <= 1'b0;
        end else begin
            read_data <= rdata;
            hit       <= sel;
        end
    end

endmodule

// File: doc/mmio_pwm_bank.md
Name: mmio_pwm_bank

Overview:
Memory-mapped, multi-channel PWM peripheral that replaces the fixed LED/RGB bits in the memory subsystem with NUM_CH independently programmable PWM outputs. It is written and read by the multicycle RISC-V core over the same address/data/write-enable bus the memory uses. The top level muxes its read_data into ReadData when `hit` is asserted. All channels share one prescaler and one period counter. Duty values are double-buffered so updates are glitch-free.

Parameters:
NUM_CH, 4, number of PWM channels (1..32).
CNT_WIDTH, 8, width of the period counter and of duty/TOP fields (1..16).
BASE_ADDR, 32'hFFFF_FF00, base of the 256-byte register window; bits [7:0] must be 0.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
write_mem  in  1  write strobe from core FSM
address  in  32  byte address (shared read/write)
write_data  in  32  store data (word accesses only)
read_data  out  32  registered read data
hit  out  1  registered flag: the previous cycle's address fell in the window
pwm  out  NUM_CH  PWM outputs

Behaviour:
- Reset (synchronous, active-high): all registers, counters, flags, read_data, hit and pwm go to 0.
- Decode: sel = (address[31:8] == BASE_ADDR[31:8]). Offset = address[7:0]; address[1:0] is ignored. All accesses are full 32-bit words.
- Register map (offset, access, meaning):
  - 0x00 CTRL, RW: bit0 EN; bits[15:8] PRESC. All other bits read 0.
  - 0x04 PERIOD, RW: bits[CNT_WIDTH-1:0] TOP.
  - 0x08 STATUS: bit0 WRAP is sticky and W1C. Bits[8+CNT_WIDTH-1:8] read the live counter value (RO).
  - 0x10+4*i DUTY[i], RW: bits[CNT_WIDTH-1:0] duty shadow; bit31 INV.
  - Unmapped offsets and channels >= NUM_CH read 0 and ignore writes.
- Write: takes effect at the clock edge where write_mem && sel.
- Read:
  - read_data and hit are registered every cycle from the current address, so latency is 1 cycle.
  - read_data = 0 when !sel.
  - A read in the same cycle as a write to the same register returns the old value.
- Prescaler:
  - pcnt counts 0..PRESC. tick = EN && (pcnt == PRESC), and pcnt returns to 0 on tick.
  - PRESC=0 gives a tick every clock.
- Period counter (cnt):
  - On tick: if cnt >= TOP then cnt <= 0 (wrap), else cnt <= cnt+1.
  - The >= compare means lowering TOP below the current cnt wraps on the next tick with no overrun.
  - TOP=0 gives a one-tick period.
- Duty buffering:
  - Each channel has an active duty register.
  - On wrap, active <= shadow for every channel and WRAP is set.
  - While EN=0, active tracks shadow every cycle.
  - INV is not buffered and applies immediately.
- Output: pwm[i] = EN ? ((cnt < active[i]) ^ INV[i]) : 0, registered with one cycle of latency from cnt/active.
  - duty=0 gives constant low (high if INV).
  - duty > TOP gives constant high.
- Enable:
  - EN 1->0: pcnt and cnt clear to 0 on the next edge, and pwm goes 0 one cycle later.
  - EN 0->1: counting starts from cnt=0, pcnt=0 using the already-loaded active duties. The first tick occurs PRESC+1 cycles after the enabling write.
- Simultaneous events:
  - A wrap and a W1C of WRAP in the same cycle leaves WRAP=1 (set wins).
  - A DUTY write in the wrap cycle: the old shadow goes to active and the new value waits for the next wrap.
- Reset mid-period: everything clears in that cycle and pwm is 0 on the following cycle.
- The counter value exported via STATUS is zero-extended to 32 bits.

Test Plan:
1. Reset, then read CTRL, PERIOD, STATUS and DUTY[0..3] -> all read 0, hit=1 one cycle after each address, pwm=0000.
2. Write PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=10, DUTY3=3|INV, CTRL=1 (PRESC=0) -> over each 10-cycle period, pwm0 is high 3 cycles, pwm1 is always 0, pwm2 is always 1, and pwm3 is the complement of pwm0. STATUS.WRAP becomes 1 after the first period.
3. With PRESC=3, PERIOD=4, DUTY0=2 -> period is 20 clocks with pwm0 high 8 clocks. First tick occurs 4 clocks after the EN write.
4. Mid-period (cnt=2) write DUTY0=5 with PERIOD=9 -> the rest of the current period keeps duty 3, and duty 5 starts exactly at the next cnt=0.
5. At cnt=8 write PERIOD=4 -> next tick wraps to 0 (no count to 255). Then force a W1C to STATUS on the wrap cycle -> WRAP reads 1.
6. Assert reset while pwm0 is high and cnt=5 -> next cycle cnt=0, pwm=0 and all registers read 0. Read address 0x0000_0100 -> read_data=0, hit=0.
